// File: rtl/bus_arb_pkg.sv
// Shared types and default widths for the two-requester bus arbiter.
package bus_arb_pkg;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;
endpackage

// File: rtl/bus_arbiter_if.sv
// Requester and core-chain signal bundle for bus_arbiter.
// slave = arbiter side, master = requesters plus chain tail.
interface bus_arbiter_if
    import bus_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_data;
    logic [1:0]          req_rw;
    logic [1:0]          resp_valid;
    logic [DATA_W-1:0]   resp_data;
    logic                resp_err;
    logic [ADDR_W-1:0]   bus_addr_o;
    logic [DATA_W-1:0]   bus_data_o;
    logic                bus_rw_o;
    logic                bus_valid_o;
    logic [DATA_W-1:0]   bus_data_i;
    logic                bus_rw_i;
    logic                bus_valid_i;

    modport slave (
        input  req_valid, req_addr, req_data, req_rw,
        input  bus_data_i, bus_rw_i, bus_valid_i,
        output req_ready, resp_valid, resp_data, resp_err,
        output bus_addr_o, bus_data_o, bus_rw_o, bus_valid_o
    );

    modport master (
        output req_valid, req_addr, req_data, req_rw,
        output bus_data_i, bus_rw_i, bus_valid_i,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  bus_addr_o, bus_data_o, bus_rw_o, bus_valid_o
    );
endinterface

// File: rtl/bus_arb_rr_pick.sv
// Two-way round-robin picker: the requester not granted last wins a tie.
module bus_arb_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    // one-hot grant, or zero when nobody requests
    always_comb begin
        gnt = req;
        if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
    end
endmodule

// File: rtl/bus_arbiter.sv
// Two-requester bus arbiter with a single outstanding transaction.
// IDLE grants, ISSUE drives the chain head for one cycle, WAIT holds for
// the chain tail, RESP pulses the completion to the granted requester.
// Optional feature macro: BUS_ARB_TIMEOUT_EN (WAIT-state timeout with error
// response after TIMEOUT cycles).
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_arbiter_if.slave  bus
);
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("bus_arbiter: TIMEOUT must be within 1..65535");
    end

    arb_state_t        state;
    logic              last;      // index granted most recently
    logic              gidx;      // index of the transaction in flight
    logic [1:0]        gnt;
    logic              bus_valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              rw_q;
    logic [1:0]        resp_vld_q;
    logic [DATA_W-1:0] resp_data_q;
    logic              err_q;
`ifdef BUS_ARB_TIMEOUT_EN
    logic [15:0]       cnt;
`else
    assign err_q = 1'b0;
`endif

    // the chain does not report its op back; only data and valid matter
    logic unused_rw_i;
    assign unused_rw_i = bus.bus_rw_i;

    bus_arb_rr_pick u_pick (
        .req  (bus.req_valid),
        .last (last),
        .gnt  (gnt)
    );

    // grant is only offered while idle, so a dropped request simply vanishes
    assign bus.req_ready = (state == IDLE) ? gnt : 2'b00;

    // FSM; the granted fields are latched straight into the bus-head
    // registers, which are zeroed on every cycle except ISSUE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= 1'b1;
            gidx        <= 1'b0;
            bus_valid_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rw_q        <= 1'b0;
            resp_vld_q  <= 2'b00;
            resp_data_q <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            err_q       <= 1'b0;
            cnt         <= '0;
`endif
        end else begin
            bus_valid_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rw_q        <= 1'b0;
            resp_vld_q  <= 2'b00;
            resp_data_q <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        gidx        <= gnt[1];
                        bus_valid_q <= 1'b1;
                        addr_q      <= bus.req_addr[(gnt[1] ? ADDR_W : 0) +: ADDR_W];
                        data_q      <= bus.req_data[(gnt[1] ? DATA_W : 0) +: DATA_W];
                        rw_q        <= bus.req_rw[gnt[1]];
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef BUS_ARB_TIMEOUT_EN
                    cnt   <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.bus_valid_i) begin
                        resp_vld_q[gidx] <= 1'b1;
                        resp_data_q      <= bus.bus_data_i;
                        state            <= RESP;
                    end
`ifdef BUS_ARB_TIMEOUT_EN
                    else if (cnt == 16'(TIMEOUT - 1)) begin
                        resp_vld_q[gidx] <= 1'b1;
                        err_q            <= 1'b1;
                        state            <= RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
`endif
                end
                RESP: begin
                    last  <= gidx;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.bus_valid_o = bus_valid_q;
    assign bus.bus_addr_o  = addr_q;
    assign bus.bus_data_o  = data_q;
    assign bus.bus_rw_o    = rw_q;
    assign bus.resp_valid  = resp_vld_q;
    assign bus.resp_data   = resp_data_q;
    assign bus.resp_err    = err_q;
endmodule
